// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Receives a program as a byte stream over a valid/ready handshake. Each
//   group of four bytes is packed big-endian into one instruction word, and
//   the words are written to consecutive instruction memory addresses. The
//   core is held while a load is in progress.
//
// Ports
//   clock, reset        system clock, async active-low reset
//   start               one-cycle load request (honoured in IDLE/DONE only)
//   baseAddress         first word address, latched at start
//   programLength       word count, latched at start
//   byteValid, byteIn   host byte stream
//   byteReady           loader accepts a byte this cycle (registered)
//   memWrite            one-cycle instruction memory write strobe
//   memAddress, memData write address/data, valid while memWrite=1
//   cpuHold             stall PC/fetch while high
//   done                load complete, held until the next start
module instr_mem_loader #(
  parameter int bits  = 32,
  parameter int addr  = 20,
  parameter int byteW = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [addr-1:0]  baseAddress,
  input  logic [addr-1:0]  programLength,
  input  logic             byteValid,
  input  logic [byteW-1:0] byteIn,
  output logic             byteReady,
  output logic             memWrite,
  output logic [addr-1:0]  memAddress,
  output logic [bits-1:0]  memData,
  output logic             cpuHold,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [addr-1:0] ONE = 1;

  state_t          state;
  logic [addr-1:0] base;
  logic [addr-1:0] len;
  logic [addr-1:0] idx;
  logic [1:0]      bcnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      base       <= '0;
      len        <= '0;
      idx        <= '0;
      bcnt       <= 2'd0;
      byteReady  <= 1'b0;
      memWrite   <= 1'b0;
      memAddress <= '0;
      memData    <= '0;
      cpuHold    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            base <= baseAddress;
            len  <= programLength;
            idx  <= '0;
            bcnt <= 2'd0;
            if (programLength == '0) begin
              // Empty program: complete immediately without touching memory.
              state     <= DONE;
              done      <= 1'b1;
              cpuHold   <= 1'b0;
              byteReady <= 1'b0;
            end else begin
              state     <= RECV;
              done      <= 1'b0;
              cpuHold   <= 1'b1;
              byteReady <= 1'b1;
            end
          end
        end

        RECV: begin
          if (byteValid && byteReady) begin
            // Shifting left puts the first byte of the group in the MSBs
            // after four accepts; all four bytes overwrite any stale data.
            memData <= {memData[bits-byteW-1:0], byteIn};
            bcnt    <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              state      <= WRITE;
              bcnt       <= 2'd0;
              byteReady  <= 1'b0;
              memWrite   <= 1'b1;
              memAddress <= base + idx;  // wraps modulo 2^addr
            end
          end
        end

        WRITE: begin
          memWrite <= 1'b0;
          if (idx == len - ONE) begin
            state   <= DONE;
            done    <= 1'b1;
            cpuHold <= 1'b0;
          end else begin
            idx       <= idx + ONE;
            state     <= RECV;
            byteReady <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
